// File: rtl/pic_pkg.sv
// Shared constants for the programmable interrupt controller: register map,
// source count and the bit layout of the VEC read word.
package pic_pkg;

    localparam int NSRC = 6;

    localparam logic [1:0] PIC_MODE = 2'd0;
    localparam logic [1:0] PIC_MASK = 2'd1;
    localparam logic [1:0] PIC_PEND = 2'd2;
    localparam logic [1:0] PIC_VEC  = 2'd3;

    localparam int VEC_VALID_BIT = 31;
    localparam int VEC_INSVC_BIT = 5;
    localparam int VEC_IDX_LSB   = 0;

    // Packs the acknowledge word returned by a VEC read.
    function automatic logic [31:0] make_vec(input logic       valid,
                                             input logic       insvc_ok,
                                             input logic [2:0] idx);
        logic [31:0] word;
        word                             = '0;
        word[VEC_VALID_BIT]              = valid;
        word[VEC_INSVC_BIT]              = insvc_ok;
        word[VEC_IDX_LSB +: 3]           = idx;
        return word;
    endfunction

endpackage

// File: rtl/pic_prio6.sv
// Six-input lowest-index priority encoder: one-hot winner, its index and a
// valid flag. Bit 0 has the highest priority.
module pic_prio6
    import pic_pkg::*;
(
    input  logic [NSRC-1:0] req,
    output logic [NSRC-1:0] onehot,
    output logic [2:0]      idx,
    output logic            valid
);

    // Scanning downwards lets the lowest set bit overwrite any higher one.
    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = 3'(i);
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pic_ctrl.sv
// Memory-mapped interrupt controller: synchronizes six device lines, latches
// edge/level requests and presents one nested, fixed-priority request to CP0.
module pic_ctrl
    import pic_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq_src,
    input  logic            dev_sel,
    input  logic [1:0]      dev_addr,
    input  logic            dev_we,
    input  logic [31:0]     dev_wd,
    output logic [31:0]     dev_rd,
    output logic [NSRC-1:0] HWInt
);

    logic [NSRC-1:0] s1, s2, s3;
    logic [NSRC-1:0] mode, mask, pending, insvc;
    logic [NSRC-1:0] cand_oh, top_oh, sel;
    logic [NSRC-1:0] rise, pend_clr, w1c_bits, pending_nxt;
    logic [2:0]      cand_idx, top_idx;
    logic            cand_valid, top_valid, eligible;
    logic            wr, ack, eoi;
    logic            unused_wd;

    assign unused_wd = ^dev_wd[31:NSRC];

    pic_prio6 u_cand (
        .req    (pending & mask),
        .onehot (cand_oh),
        .idx    (cand_idx),
        .valid  (cand_valid)
    );

    pic_prio6 u_top (
        .req    (insvc),
        .onehot (top_oh),
        .idx    (top_idx),
        .valid  (top_valid)
    );

    // A candidate only preempts if it outranks every source already in service.
    assign eligible = cand_valid & (~top_valid | (cand_idx < top_idx));
    assign sel      = eligible ? cand_oh : '0;

    assign wr  = dev_sel & dev_we;
    assign ack = dev_sel & ~dev_we & (dev_addr == PIC_VEC) & eligible;
    assign eoi = wr & (dev_addr == PIC_VEC);

    // Clears touch edge-mode bits only; a fresh edge wins over a same-cycle clear.
    assign rise        = s2 & ~s3;
    assign w1c_bits    = (wr && dev_addr == PIC_PEND) ? dev_wd[NSRC-1:0] : '0;
    assign pend_clr    = mode & (w1c_bits | (ack ? sel : '0));
    assign pending_nxt = (mode & ((pending & ~pend_clr) | rise)) | (~mode & s2);

    // Two-flop synchronizer plus a third stage for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= irq_src;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode    <= '0;
            mask    <= '0;
            pending <= '0;
            insvc   <= '0;
            HWInt   <= '0;
        end else begin
            if (wr && dev_addr == PIC_MODE) mode <= dev_wd[NSRC-1:0];
            if (wr && dev_addr == PIC_MASK) mask <= dev_wd[NSRC-1:0];
            pending <= pending_nxt;
            if (ack)
                insvc <= insvc | sel;
            else if (eoi)
                insvc <= insvc & ~top_oh;
            HWInt <= sel;
        end
    end

    // Read data is combinational so the MEM stage sees it in the same cycle.
    always_comb begin
        dev_rd = '0;
        if (!rst && dev_sel && !dev_we) begin
            case (dev_addr)
                PIC_MODE: dev_rd[NSRC-1:0] = mode;
                PIC_MASK: dev_rd[NSRC-1:0] = mask;
                PIC_PEND: dev_rd[NSRC-1:0] = pending;
                PIC_VEC:  if (eligible) dev_rd = make_vec(1'b1, |insvc, cand_idx);
                default:  dev_rd = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_pic_ctrl.sv
// Directed self-checking bench for pic_ctrl with hand-computed expectations.
module tb_pic_ctrl;

    logic        clk;
    logic        rst;
    logic [5:0]  irq_src;
    logic        dev_sel;
    logic [1:0]  dev_addr;
    logic        dev_we;
    logic [31:0] dev_wd;
    logic [31:0] dev_rd;
    logic [5:0]  HWInt;

    int compared;
    int mismatched;
    logic [31:0] rdata;

    pic_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .irq_src  (irq_src),
        .dev_sel  (dev_sel),
        .dev_addr (dev_addr),
        .dev_we   (dev_we),
        .dev_wd   (dev_wd),
        .dev_rd   (dev_rd),
        .HWInt    (HWInt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic busWrite(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        dev_sel  = 1'b1;
        dev_we   = 1'b1;
        dev_addr = addr;
        dev_wd   = data;
        @(posedge clk);
        #1;
        dev_sel = 1'b0;
        dev_we  = 1'b0;
        dev_wd  = '0;
    endtask

    task automatic busRead(input logic [1:0] addr, output logic [31:0] data);
        @(negedge clk);
        dev_sel  = 1'b1;
        dev_we   = 1'b0;
        dev_addr = addr;
        #1;
        data = dev_rd;
        @(posedge clk);
        #1;
        dev_sel = 1'b0;
    endtask

    task automatic pulseSrc(input int i, input int cycles);
        irq_src[i] = 1'b1;
        tick(cycles);
        irq_src[i] = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        irq_src    = '0;
        dev_sel    = 1'b1;
        dev_we     = 1'b0;
        dev_addr   = 2'd0;
        dev_wd     = '0;
        tick(2);
        checkOutput("reset_hwint", 32'(HWInt), 32'h0);
        checkOutput("reset_rd", dev_rd, 32'h0);
        @(negedge clk);
        dev_sel = 1'b0;
        rst     = 1'b0;
        tick(1);

        // Edge path on source 0
        busWrite(2'd0, 32'h01);
        busWrite(2'd1, 32'h01);
        irq_src[0] = 1'b1;
        tick(3);
        checkOutput("edge_hwint_3edges", 32'(HWInt), 32'h0);
        irq_src[0] = 1'b0;
        tick(1);
        checkOutput("edge_hwint_4edges", 32'(HWInt), 32'h01);
        busRead(2'd3, rdata);
        checkOutput("edge_ack", rdata, 32'h8000_0000);
        checkOutput("edge_hwint_ackedge", 32'(HWInt), 32'h01);
        tick(1);
        checkOutput("edge_hwint_after", 32'(HWInt), 32'h0);
        busRead(2'd2, rdata);
        checkOutput("edge_pend_clr", rdata, 32'h0);
        busWrite(2'd3, 32'h0);

        // Reset mid-run with source 2 in service
        busWrite(2'd0, 32'h04);
        busWrite(2'd1, 32'h04);
        pulseSrc(2, 3);
        tick(1);
        busRead(2'd3, rdata);
        checkOutput("rst_pre_ack", rdata, 32'h8000_0002);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_hwint", 32'(HWInt), 32'h0);
        for (int a = 0; a < 4; a++) begin
            busRead(2'(a), rdata);
            checkOutput($sformatf("rst_rd%0d", a), rdata, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        busRead(2'd0, rdata);
        checkOutput("rst_mode", rdata, 32'h0);
        busRead(2'd1, rdata);
        checkOutput("rst_mask", rdata, 32'h0);

        // Level path on source 3; also proves insvc[2] did not survive reset
        busWrite(2'd1, 32'h08);
        irq_src[3] = 1'b1;
        tick(4);
        checkOutput("lvl_hwint", 32'(HWInt), 32'h08);
        busRead(2'd2, rdata);
        checkOutput("lvl_pend", rdata, 32'h08);
        busRead(2'd3, rdata);
        checkOutput("lvl_ack", rdata, 32'h8000_0003);
        tick(1);
        checkOutput("lvl_hwint_insvc", 32'(HWInt), 32'h0);
        busWrite(2'd2, 32'h08);
        busRead(2'd2, rdata);
        checkOutput("lvl_w1c_ignored", rdata, 32'h08);
        tick(2);
        checkOutput("lvl_hwint_blocked", 32'(HWInt), 32'h0);
        busWrite(2'd3, 32'h0);
        checkOutput("lvl_hwint_eoi_edge", 32'(HWInt), 32'h0);
        tick(1);
        checkOutput("lvl_hwint_reassert", 32'(HWInt), 32'h08);
        irq_src[3] = 1'b0;
        tick(3);
        busRead(2'd2, rdata);
        checkOutput("lvl_pend_drop", rdata, 32'h0);

        // Nesting: 4 in service, then 1 preempts, 5 waits for both EOIs
        busWrite(2'd0, 32'h3F);
        busWrite(2'd1, 32'h3F);
        pulseSrc(4, 3);
        tick(1);
        checkOutput("nest_hwint4", 32'(HWInt), 32'h10);
        busRead(2'd3, rdata);
        checkOutput("nest_ack4", rdata, 32'h8000_0004);
        pulseSrc(1, 3);
        tick(1);
        checkOutput("nest_hwint1", 32'(HWInt), 32'h02);
        busRead(2'd3, rdata);
        checkOutput("nest_ack1", rdata, 32'h8000_0021);
        pulseSrc(5, 3);
        tick(2);
        checkOutput("nest_blk5_a", 32'(HWInt), 32'h0);
        busWrite(2'd3, 32'h0);
        tick(2);
        checkOutput("nest_blk5_b", 32'(HWInt), 32'h0);
        busWrite(2'd3, 32'h0);
        checkOutput("nest_eoi2_edge", 32'(HWInt), 32'h0);
        tick(1);
        checkOutput("nest_hwint5", 32'(HWInt), 32'h20);
        busRead(2'd3, rdata);
        checkOutput("nest_ack5", rdata, 32'h8000_0005);
        busWrite(2'd3, 32'h0);
        busRead(2'd2, rdata);
        checkOutput("nest_pend_empty", rdata, 32'h0);

        // Conflicts: edge beats W1C, ACK with nothing eligible, idle EOI
        busWrite(2'd1, 32'h00);
        irq_src[2] = 1'b1;
        tick(2);
        busWrite(2'd2, 32'h04);
        busRead(2'd2, rdata);
        checkOutput("cf_edge_beats_w1c", rdata, 32'h04);
        irq_src[2] = 1'b0;
        busWrite(2'd2, 32'h04);
        busRead(2'd2, rdata);
        checkOutput("cf_w1c", rdata, 32'h0);
        pulseSrc(0, 3);
        tick(2);
        busRead(2'd3, rdata);
        checkOutput("cf_ack_none", rdata, 32'h0);
        busRead(2'd2, rdata);
        checkOutput("cf_ack_none_pend", rdata, 32'h01);
        busWrite(2'd3, 32'h0);
        busRead(2'd2, rdata);
        checkOutput("cf_eoi_idle_pend", rdata, 32'h01);
        busWrite(2'd1, 32'h01);
        tick(1);
        checkOutput("cf_hwint0", 32'(HWInt), 32'h01);
        busRead(2'd3, rdata);
        checkOutput("cf_ack0", rdata, 32'h8000_0000);
        busWrite(2'd3, 32'h0);

        // Masking a held level request on source 5
        busWrite(2'd0, 32'h00);
        busWrite(2'd1, 32'h20);
        irq_src[5] = 1'b1;
        tick(4);
        checkOutput("msk_hwint_on", 32'(HWInt), 32'h20);
        busWrite(2'd1, 32'h00);
        checkOutput("msk_write_edge", 32'(HWInt), 32'h20);
        tick(1);
        checkOutput("msk_hwint_off", 32'(HWInt), 32'h0);
        busWrite(2'd1, 32'h20);
        checkOutput("msk_reen_edge", 32'(HWInt), 32'h0);
        tick(1);
        checkOutput("msk_hwint_back", 32'(HWInt), 32'h20);
        irq_src[5] = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
